// File: rtl/cart_mem_responder.sv
// Memory-side responder for the cartridge mapper: serves ROM reads and cart-RAM reads/writes
// from a shared 16-bit SDRAM port using per-type pending slots, fixed priority and an ack timeout.
module cart_mem_responder #(
  parameter logic [24:0] CRAM_BASE  = 25'h0800000,
  parameter int          TIMEOUT    = 64,
  parameter bit          ROM_TAG_EN = 1'b1
) (
  input  logic        clk_sys_i,
  input  logic        reset_n_i,
  input  logic        ce_cpu_i,
  input  logic        rom_rd_i,
  input  logic [22:0] rom_addr_i,
  input  logic        cram_rd_i,
  input  logic        cram_wr_i,
  input  logic [16:0] cram_addr_i,
  input  logic [7:0]  cram_wdata_i,
  input  logic        ram_enabled_i,
  output logic [7:0]  rom_di_o,
  output logic [7:0]  cram_di_o,
  output logic        busy_o,
  output logic [1:0]  err_o,
  output logic        sd_req_o,
  output logic        sd_we_o,
  output logic [24:0] sd_addr_o,
  output logic [1:0]  sd_be_o,
  output logic [15:0] sd_wdata_o,
  input  logic        sd_ack_i,
  input  logic [15:0] sd_rdata_i
);

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic [1:0] {ACC_WR, ACC_RRD, ACC_ROM} acc_e;

  localparam int             CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  state_e        state_q;
  acc_e          acc_q;
  logic [CW-1:0] cnt_q;

  logic          wr_full_q, rrd_full_q, rom_full_q;
  logic [16:0]   wr_addr_q, rrd_addr_q;
  logic [7:0]    wr_data_q;
  logic [22:0]   rom_addr_q;

  logic          tag_valid_q;
  logic [21:0]   tag_q;
  logic [15:0]   tag_word_q;

  logic [7:0]    rom_di_q, cram_di_q;
  logic [1:0]    err_q;
  logic          sd_req_q, sd_we_q;
  logic [24:0]   sd_addr_q;
  logic [1:0]    sd_be_q;
  logic [15:0]   sd_wdata_q;

  logic          issue_wr_d, issue_rrd_d, issue_rom_d, tag_hit_d;
  logic [24:0]   wr_sd_addr_d, rrd_sd_addr_d;
  logic [7:0]    ack_byte_d, tag_byte_d;

  always_comb begin
    issue_wr_d    = (state_q == IDLE) && wr_full_q;
    issue_rrd_d   = (state_q == IDLE) && !wr_full_q && rrd_full_q;
    issue_rom_d   = (state_q == IDLE) && !wr_full_q && !rrd_full_q && rom_full_q;
    wr_sd_addr_d  = CRAM_BASE + {8'h00, wr_addr_q};
    rrd_sd_addr_d = CRAM_BASE + {8'h00, rrd_addr_q};
    ack_byte_d    = sd_addr_q[0] ? sd_rdata_i[15:8] : sd_rdata_i[7:0];
    tag_byte_d    = rom_addr_i[0] ? tag_word_q[15:8] : tag_word_q[7:0];
    tag_hit_d     = ROM_TAG_EN && tag_valid_q && (rom_addr_i[22:1] == tag_q);
  end

  // Capture is written after issue/completion so a new request refills a slot drained this cycle.
  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      acc_q       <= ACC_WR;
      cnt_q       <= '0;
      wr_full_q   <= 1'b0;
      rrd_full_q  <= 1'b0;
      rom_full_q  <= 1'b0;
      wr_addr_q   <= '0;
      rrd_addr_q  <= '0;
      wr_data_q   <= '0;
      rom_addr_q  <= '0;
      tag_valid_q <= 1'b0;
      tag_q       <= '0;
      tag_word_q  <= '0;
      rom_di_q    <= 8'hFF;
      cram_di_q   <= 8'hFF;
      err_q       <= 2'b00;
      sd_req_q    <= 1'b0;
      sd_we_q     <= 1'b0;
      sd_addr_q   <= '0;
      sd_be_q     <= 2'b00;
      sd_wdata_q  <= '0;
    end else begin
      if (issue_wr_d) begin
        wr_full_q  <= 1'b0;
        sd_req_q   <= 1'b1;
        sd_we_q    <= 1'b1;
        sd_addr_q  <= wr_sd_addr_d;
        sd_be_q    <= wr_sd_addr_d[0] ? 2'b10 : 2'b01;
        sd_wdata_q <= {wr_data_q, wr_data_q};
        acc_q      <= ACC_WR;
        cnt_q      <= '0;
        state_q    <= WAIT;
      end else if (issue_rrd_d) begin
        rrd_full_q <= 1'b0;
        sd_req_q   <= 1'b1;
        sd_we_q    <= 1'b0;
        sd_addr_q  <= rrd_sd_addr_d;
        sd_be_q    <= 2'b00;
        sd_wdata_q <= '0;
        acc_q      <= ACC_RRD;
        cnt_q      <= '0;
        state_q    <= WAIT;
      end else if (issue_rom_d) begin
        rom_full_q <= 1'b0;
        sd_req_q   <= 1'b1;
        sd_we_q    <= 1'b0;
        sd_addr_q  <= {2'b00, rom_addr_q};
        sd_be_q    <= 2'b00;
        sd_wdata_q <= '0;
        acc_q      <= ACC_ROM;
        cnt_q      <= '0;
        state_q    <= WAIT;
      end

      if (state_q == WAIT) begin
        if (sd_ack_i) begin
          sd_req_q <= 1'b0;
          state_q  <= IDLE;
          case (acc_q)
            ACC_RRD: cram_di_q <= ack_byte_d;
            ACC_ROM: begin
              rom_di_q    <= ack_byte_d;
              tag_q       <= sd_addr_q[22:1];
              tag_word_q  <= sd_rdata_i;
              tag_valid_q <= 1'b1;
            end
            default: ;
          endcase
        end else if (cnt_q == TO_LAST) begin
          sd_req_q <= 1'b0;
          err_q[0] <= 1'b1;
          state_q  <= IDLE;
          case (acc_q)
            ACC_RRD: cram_di_q <= 8'hFF;
            ACC_ROM: rom_di_q  <= 8'hFF;
            default: ;
          endcase
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      if (ce_cpu_i) begin
        if (cram_wr_i && ram_enabled_i) begin
          if (wr_full_q && !issue_wr_d) err_q[1] <= 1'b1;
          wr_full_q <= 1'b1;
          wr_addr_q <= cram_addr_i;
          wr_data_q <= cram_wdata_i;
        end
        if (cram_rd_i) begin
          if (ram_enabled_i) begin
            if (rrd_full_q && !issue_rrd_d) err_q[1] <= 1'b1;
            rrd_full_q <= 1'b1;
            rrd_addr_q <= cram_addr_i;
          end else begin
            cram_di_q <= 8'hFF;
          end
        end
        if (rom_rd_i) begin
          if (tag_hit_d) begin
            rom_di_q <= tag_byte_d;
          end else begin
            if (rom_full_q && !issue_rom_d) err_q[1] <= 1'b1;
            rom_full_q <= 1'b1;
            rom_addr_q <= rom_addr_i;
          end
        end
      end
    end
  end

  assign busy_o     = wr_full_q || rrd_full_q || rom_full_q || (state_q != IDLE);
  assign rom_di_o   = rom_di_q;
  assign cram_di_o  = cram_di_q;
  assign err_o      = err_q;
  assign sd_req_o   = sd_req_q;
  assign sd_we_o    = sd_we_q;
  assign sd_addr_o  = sd_addr_q;
  assign sd_be_o    = sd_be_q;
  assign sd_wdata_o = sd_wdata_q;

endmodule
